// File: rtl/dmac_minmax_pkg.sv
// ---------------------------------------------------------------------------
// dmac_minmax_pkg
//   Shared types and helpers for the DMAC min/max comparison tree.
//   - MM_WIDTH / MM_INDEX_WIDTH : element and index widths of a tree node.
//     dmac_minmax_pipe must be instantiated with WIDTH == MM_WIDTH and
//     INDEX_WIDTH == MM_INDEX_WIDTH; NUM_INPUTS is free (2..LEAVES).
//   - LEAVES                    : tree width after padding to a power of two.
//   - node_t                    : record carried by every tree node.
//   - beats()                   : "a strictly beats b" under tc / min_max.
// ---------------------------------------------------------------------------
package dmac_minmax_pkg;

  localparam int MM_WIDTH       = 4;
  localparam int MM_INDEX_WIDTH = 3;
  localparam int LEAVES         = 2 ** MM_INDEX_WIDTH;

  typedef struct packed {
    logic [MM_WIDTH-1:0]       value;
    logic [MM_INDEX_WIDTH-1:0] index;
    logic                      vld;
    logic                      tc;
    logic                      min_max;
  } node_t;

  // Two's complement ordering is obtained by flipping the sign bit of both
  // operands and comparing unsigned, so no width growth is needed.
  function automatic logic beats(input logic [MM_WIDTH-1:0] a,
                                 input logic [MM_WIDTH-1:0] b,
                                 input logic                tc,
                                 input logic                min_max);
    logic [MM_WIDTH-1:0] ka;
    logic [MM_WIDTH-1:0] kb;
    ka = a;
    kb = b;
    if (tc) begin
      ka[MM_WIDTH-1] = ~ka[MM_WIDTH-1];
      kb[MM_WIDTH-1] = ~kb[MM_WIDTH-1];
    end
    return min_max ? (ka > kb) : (ka < kb);
  endfunction

endpackage

// File: rtl/dmac_minmax_node.sv
// ---------------------------------------------------------------------------
// dmac_minmax_node
//   Combinational two-input merge of the comparison tree.
//   Ports:
//     left   : node record from the lower-index subtree
//     right  : node record from the higher-index subtree
//     merged : winning record (carries its own value, index, mode)
//   An invalid child always loses; with both valid the right child only wins
//   when strictly better, so equal values resolve to the lower index.
// ---------------------------------------------------------------------------
module dmac_minmax_node
  import dmac_minmax_pkg::*;
(
  input  node_t left,
  input  node_t right,
  output node_t merged
);

  logic right_wins;

  always_comb begin
    right_wins = 1'b0;
    if (right.vld && !left.vld) begin
      right_wins = 1'b1;
    end else if (right.vld && left.vld) begin
      right_wins = beats(right.value, left.value, left.tc, left.min_max);
    end
  end

  assign merged = right_wins ? right : left;

endmodule

// File: rtl/dmac_minmax_pipe.sv
// ---------------------------------------------------------------------------
// dmac_minmax_pipe
//   Streaming min/max finder for the DMAC channel-arbitration path. One vector
//   of NUM_INPUTS elements per cycle enters a registered comparison tree of
//   INDEX_WIDTH levels; the extremum and its index leave on a valid/ready
//   handshake INDEX_WIDTH cycles after acceptance.
//
//   Ports:
//     hclk, hreset          : clock, synchronous active-high reset
//     in_valid / in_ready   : input handshake (in_ready = not stalled)
//     in_a                  : element i = in_a[i*WIDTH +: WIDTH]
//     in_mask               : 1 = element participates
//     in_tc                 : 0 unsigned, 1 two's complement
//     in_min_max            : 0 min, 1 max
//     out_valid / out_ready : output handshake
//     out_value, out_index  : extremum and its lowest index (0 when none)
//     out_none              : mask was all zero
//
//   Optional build macro DMAC_MINMAX_ACCUM_EN adds:
//     in_acc                : merge this result with the last emitted one
//     out_acc_hit           : the previously emitted result won
//
//   WIDTH and INDEX_WIDTH must match MM_WIDTH / MM_INDEX_WIDTH of the package.
// ---------------------------------------------------------------------------
module dmac_minmax_pipe
  import dmac_minmax_pkg::*;
#(
  parameter int WIDTH       = MM_WIDTH,
  parameter int NUM_INPUTS  = 8,
  parameter int INDEX_WIDTH = MM_INDEX_WIDTH
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_a,
  input  logic [NUM_INPUTS-1:0]       in_mask,
  input  logic                        in_tc,
  input  logic                        in_min_max,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_value,
  output logic [INDEX_WIDTH-1:0]      out_index,
  output logic                        out_none
`ifdef DMAC_MINMAX_ACCUM_EN
  ,
  input  logic                        in_acc,
  output logic                        out_acc_hit
`endif
);

  logic stall;
  logic accept;
  logic root_en;
  logic [INDEX_WIDTH:1] vld_p;

  // Heap numbering: node 1 is the root, node i has children 2i and 2i+1,
  // leaves occupy LEAVES .. 2*LEAVES-1 in element order.
  node_t src    [2:2*LEAVES-1];
  node_t merged [1:LEAVES-1];

  logic [WIDTH-1:0]       out_value_q;
  logic [INDEX_WIDTH-1:0] out_index_q;
  logic                   out_none_q;

  // The whole pipe freezes while the output is held, so no bubble collapsing.
  assign stall     = vld_p[INDEX_WIDTH] & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & ~stall;
  assign out_valid = vld_p[INDEX_WIDTH];
  assign root_en   = (INDEX_WIDTH == 1) ? accept : ~stall;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      vld_p <= '0;
    end else if (!stall) begin
      vld_p[1] <= in_valid;
      for (int s = 2; s <= INDEX_WIDTH; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  // ---- stage 0: leaves, padded up to LEAVES with masked-off entries ----
  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < NUM_INPUTS) begin : g_used
      assign src[LEAVES+j] = '{value:   in_a[j*WIDTH +: WIDTH],
                               index:   MM_INDEX_WIDTH'(j),
                               vld:     in_mask[j],
                               tc:      in_tc,
                               min_max: in_min_max};
    end else begin : g_pad
      assign src[LEAVES+j] = '{value:   '0,
                               index:   MM_INDEX_WIDTH'(j),
                               vld:     1'b0,
                               tc:      in_tc,
                               min_max: in_min_max};
    end
  end

  // ---- stages 1 .. INDEX_WIDTH-1: one register per internal node ----
  for (genvar i = 1; i < LEAVES; i++) begin : g_node
    // Depth of node i is floor(log2(i)); deepest internal level is stage 1.
    localparam int STG = INDEX_WIDTH - ($clog2(i + 1) - 1);

    dmac_minmax_node u_node (
      .left   (src[2*i]),
      .right  (src[2*i+1]),
      .merged (merged[i])
    );

    if (i >= 2) begin : g_reg
      logic  en;
      node_t node_p;

      if (STG == 1) begin : g_first
        assign en = accept;
      end else begin : g_inner
        assign en = ~stall;
      end

      always_ff @(posedge hclk) begin
        if (en) begin
          node_p <= merged[i];
        end
      end

      assign src[i] = node_p;
    end
  end

  // ---- stage INDEX_WIDTH: root result lands in the output registers ----
  always_ff @(posedge hclk) begin
    if (hreset) begin
      out_value_q <= '0;
      out_index_q <= '0;
      out_none_q  <= 1'b0;
    end else if (root_en) begin
      out_value_q <= merged[1].vld ? merged[1].value : '0;
      out_index_q <= merged[1].vld ? merged[1].index : '0;
      out_none_q  <= ~merged[1].vld;
    end
  end

`ifdef DMAC_MINMAX_ACCUM_EN
  logic [INDEX_WIDTH:1]   acc_p;
  logic                   out_tc_q;
  logic                   out_mm_q;
  logic [WIDTH-1:0]       held_value;
  logic [INDEX_WIDTH-1:0] held_index;
  logic                   held_none;
  logic                   sel_held;

  // Accumulate flag rides with the stage valid bits.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      acc_p <= '0;
    end else if (!stall) begin
      acc_p[1] <= in_valid & in_acc;
      for (int s = 2; s <= INDEX_WIDTH; s++) begin
        acc_p[s] <= acc_p[s-1];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      out_tc_q <= 1'b0;
      out_mm_q <= 1'b0;
    end else if (root_en) begin
      out_tc_q <= merged[1].tc;
      out_mm_q <= merged[1].min_max;
    end
  end

  // The held result keeps ties; an empty held result loses to anything.
  always_comb begin
    sel_held = 1'b0;
    if (acc_p[INDEX_WIDTH] && !held_none) begin
      if (out_none_q) begin
        sel_held = 1'b1;
      end else begin
        sel_held = ~beats(out_value_q, held_value, out_tc_q, out_mm_q);
      end
    end
  end

  assign out_value   = sel_held ? held_value : out_value_q;
  assign out_index   = sel_held ? held_index : out_index_q;
  assign out_none    = sel_held ? 1'b0       : out_none_q;
  assign out_acc_hit = sel_held;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      held_value <= '0;
      held_index <= '0;
      held_none  <= 1'b1;
    end else if (out_valid && out_ready) begin
      held_value <= out_value;
      held_index <= out_index;
      held_none  <= out_none;
    end
  end
`else
  logic unused_root_mode;

  assign unused_root_mode = merged[1].tc ^ merged[1].min_max;
  assign out_value        = out_value_q;
  assign out_index        = out_index_q;
  assign out_none         = out_none_q;
`endif

endmodule

// File: tb/tb_dmac_minmax_pipe.sv
// ---------------------------------------------------------------------------
// tb_dmac_minmax_pipe
//   Scoreboard bench for dmac_minmax_pipe (8-input and 5-input instances).
//   Expected results come from a plain-arithmetic reference model; a monitor
//   pops and compares on every output handshake.
//   Build with DMAC_MINMAX_ACCUM_EN to exercise the accumulate option.
// ---------------------------------------------------------------------------
module tb_dmac_minmax_pipe;

  localparam int W  = 4;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int N5 = 5;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic          hreset;
  logic          in_valid, in_ready;
  logic [N*W-1:0] in_a;
  logic [N-1:0]  in_mask;
  logic          in_tc, in_min_max;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_value;
  logic [IW-1:0] out_index;
  logic          out_none;

  logic           in_valid5, in_ready5;
  logic [N5*W-1:0] in_a5;
  logic [N5-1:0]  in_mask5;
  logic           in_tc5, in_min_max5;
  logic           out_valid5, out_ready5;
  logic [W-1:0]   out_value5;
  logic [IW-1:0]  out_index5;
  logic           out_none5;

`ifdef DMAC_MINMAX_ACCUM_EN
  logic in_acc, out_acc_hit;
  logic in_acc5, out_acc_hit5;
`endif

  dmac_minmax_pipe #(.WIDTH(W), .NUM_INPUTS(N), .INDEX_WIDTH(IW)) u_dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_mask    (in_mask),
    .in_tc      (in_tc),
    .in_min_max (in_min_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_index  (out_index),
    .out_none   (out_none)
`ifdef DMAC_MINMAX_ACCUM_EN
    ,
    .in_acc     (in_acc),
    .out_acc_hit(out_acc_hit)
`endif
  );

  dmac_minmax_pipe #(.WIDTH(W), .NUM_INPUTS(N5), .INDEX_WIDTH(IW)) u_dut5 (
    .hclk       (hclk),
    .hreset     (hreset),
    .in_valid   (in_valid5),
    .in_ready   (in_ready5),
    .in_a       (in_a5),
    .in_mask    (in_mask5),
    .in_tc      (in_tc5),
    .in_min_max (in_min_max5),
    .out_valid  (out_valid5),
    .out_ready  (out_ready5),
    .out_value  (out_value5),
    .out_index  (out_index5),
    .out_none   (out_none5)
`ifdef DMAC_MINMAX_ACCUM_EN
    ,
    .in_acc     (in_acc5),
    .out_acc_hit(out_acc_hit5)
`endif
  );

  typedef struct {
    logic [W-1:0]  value;
    logic [IW-1:0] index;
    logic          none;
    logic          hit;
    int            id;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   vec_id = 0;
  bit   rand_rdy = 1'b0;

  // Model of the last emitted result (used by the accumulate option).
  logic          held_none_m  = 1'b1;
  logic [W-1:0]  held_value_m = '0;
  logic [IW-1:0] held_index_m = '0;

  function automatic int keyv(input logic [W-1:0] v, input logic tc);
    if (tc) return int'($signed(v));
    return int'(v);
  endfunction

  // Scan elements in index order; replace only on strict improvement.
  function automatic exp_t ref_plain(input logic [N*W-1:0] a, input logic [N-1:0] m,
                                     input logic tc, input logic mm);
    exp_t r;
    int   best;
    r = '{value: '0, index: '0, none: 1'b1, hit: 1'b0, id: 0};
    best = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        int k;
        k = keyv(a[i*W +: W], tc);
        if (r.none || (mm ? (k > best) : (k < best))) begin
          best    = k;
          r.value = a[i*W +: W];
          r.index = IW'(i);
          r.none  = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] v, input logic [IW-1:0] i, input logic n);
    exp_t r;
    r = '{value: v, index: i, none: n, hit: 1'b0, id: 0};
    return r;
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Drive one vector and push its expected result once acceptance is seen.
  task automatic send(input logic [N*W-1:0] a, input logic [N-1:0] m, input logic tc,
                      input logic mm, input logic acc, input bit use_x, input exp_t xv);
    exp_t e;
    bit   ok;
    e = use_x ? xv : ref_plain(a, m, tc, mm);
`ifdef DMAC_MINMAX_ACCUM_EN
    if (acc && !held_none_m) begin
      int kr, kh;
      kr = keyv(e.value, tc);
      kh = keyv(held_value_m, tc);
      if (e.none || !(mm ? (kr > kh) : (kr < kh))) begin
        e.value = held_value_m;
        e.index = held_index_m;
        e.none  = 1'b0;
        e.hit   = 1'b1;
      end
    end
    in_acc = acc;
`else
    if (acc) e.hit = 1'b0;
`endif
    e.id = vec_id;
    vec_id++;
    held_none_m  = e.none;
    held_value_m = e.value;
    held_index_m = e.index;
    in_a       = a;
    in_mask    = m;
    in_tc      = tc;
    in_min_max = mm;
    in_valid   = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge hclk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back(e);
    end else begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: vector %0d not accepted in 200 cycles", e.id);
    end
    @(posedge hclk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge hclk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic run5(input logic [N5*W-1:0] a, input logic [N5-1:0] m, input logic tc,
                      input logic mm, input logic [W-1:0] ev, input logic [IW-1:0] ei);
    bit seen;
    in_a5 = a; in_mask5 = m; in_tc5 = tc; in_min_max5 = mm; in_valid5 = 1'b1;
    @(negedge hclk);
    check("n5_in_ready", in_ready5, 1);
    @(posedge hclk);
    #1;
    in_valid5 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge hclk);
      if (out_valid5) begin
        seen = 1'b1;
        break;
      end
    end
    check("n5_out_valid", seen, 1);
    check("n5_value", out_value5, ev);
    check("n5_index", out_index5, ei);
    check("n5_none", out_none5, 0);
    @(posedge hclk);
    #1;
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge hclk) begin
    if (!hreset && out_valid && out_ready) begin
      exp_t e;
      logic hit_dut;
`ifdef DMAC_MINMAX_ACCUM_EN
      hit_dut = out_acc_hit;
`else
      hit_dut = 1'b0;
`endif
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got value=%0h index=%0d none=%0d, expected no output",
                 out_value, out_index, out_none);
      end else begin
        e = exp_q.pop_front();
        if (out_value !== e.value || out_index !== e.index || out_none !== e.none ||
            hit_dut !== e.hit) begin
          fails++;
          $display("FAIL result#%0d: got value=%0h index=%0d none=%0d hit=%0d, expected value=%0h index=%0d none=%0d hit=%0d",
                   e.id, out_value, out_index, out_none, hit_dut, e.value, e.index, e.none, e.hit);
        end
      end
    end
  end

  always @(posedge hclk) begin
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none_x;
    int   lat;
    bit   seen;
    int   spurious;
    none_x = mk('0, '0, 1'b0);

    hreset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_mask = '0; in_tc = 1'b0; in_min_max = 1'b0;
    out_ready = 1'b1;
    in_valid5 = 1'b0; in_a5 = '0; in_mask5 = '0; in_tc5 = 1'b0; in_min_max5 = 1'b0;
    out_ready5 = 1'b1;
`ifdef DMAC_MINMAX_ACCUM_EN
    in_acc = 1'b0; in_acc5 = 1'b0;
`endif
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;

    // Reset state
    @(negedge hclk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_none", out_none, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge hclk);
    #1;

    // Unsigned max with a duplicated maximum, plus latency
    send({4'h4, 4'h5, 4'h2, 4'h0, 4'h9, 4'h3, 4'h9, 4'h1}, 8'hFF, 1'b0, 1'b1, 1'b0,
         1'b1, mk(4'h9, 3'd1, 1'b0));
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge hclk);
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("latency_seen", seen, 1);
    check("latency", lat, 3);
    drain("drain_umax");

    // Signed vs unsigned min on the same vector, back to back
    send(32'h0000_0F87, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, mk(4'h8, 3'd1, 1'b0));
    send(32'h0000_0F87, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, mk(4'h0, 3'd3, 1'b0));
    // Empty mask and single top element
    send(32'h1234_5678, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, mk(4'h0, 3'd0, 1'b1));
    send(32'h5FFF_FFFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, mk(4'h5, 3'd7, 1'b0));
    drain("drain_directed");

    // Stream of 10 with alternating mode and a 4-cycle output stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send($urandom, 8'($urandom), 1'($urandom), 1'(i % 2), 1'b0, 1'b0, none_x);
        end
      end
      begin
        repeat (6) @(posedge hclk);
        #2;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge hclk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          if (k < 3) @(posedge hclk);
        end
        @(posedge hclk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("drain_stream");

    // Five-input instance: padded leaves and tie resolution
    run5({5{4'hA}}, 5'h1F, 1'b0, 1'b1, 4'hA, 3'd0);
    run5({4'h9, 4'h7, 4'h0, 4'h0, 4'h0}, 5'h18, 1'b1, 1'b1, 4'h7, 3'd3);

    // Reset with two vectors in flight
    send($urandom, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, none_x);
    send($urandom, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, none_x);
    hreset = 1'b1;
    exp_q.delete();
    held_none_m = 1'b1; held_value_m = '0; held_index_m = '0;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("flush_out_valid", out_valid, 0);
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge hclk);
      if (out_valid) spurious++;
    end
    check("flush_no_stale", spurious, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge hclk);
    #1;

`ifdef DMAC_MINMAX_ACCUM_EN
    // Held result keeps a tie against a later, lower-index equal value
    send({4'h1, 4'h2, 4'h3, 4'h0, 4'h1, 4'h6, 4'h5, 4'h4}, 8'hFF, 1'b0, 1'b1, 1'b0,
         1'b0, none_x);
    send({4'h1, 4'h2, 4'h3, 4'h0, 4'h1, 4'h2, 4'h5, 4'h6}, 8'hFF, 1'b0, 1'b1, 1'b1,
         1'b0, none_x);
    drain("drain_accum");
`endif

    // Randomized traffic with random backpressure and gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send($urandom, m, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, none_x);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge hclk);
        #1;
      end
    end
    @(posedge hclk);
    rand_rdy = 1'b0;
    #3;
    out_ready = 1'b1;
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
